// File: rtl/updown_counter_7seg_pkg.sv
// Shared constants for the up/down counter: active-low abcdefg segment patterns
// for hex digits 0..F and the direction encoding of the 'up' input.
package updown_counter_7seg_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // bit6 = a ... bit0 = g, lit segment = 0
    localparam logic [6:0] SEG_0 = 7'h01;
    localparam logic [6:0] SEG_1 = 7'h4F;
    localparam logic [6:0] SEG_2 = 7'h12;
    localparam logic [6:0] SEG_3 = 7'h06;
    localparam logic [6:0] SEG_4 = 7'h4C;
    localparam logic [6:0] SEG_5 = 7'h24;
    localparam logic [6:0] SEG_6 = 7'h20;
    localparam logic [6:0] SEG_7 = 7'h0F;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h04;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h60;
    localparam logic [6:0] SEG_C = 7'h31;
    localparam logic [6:0] SEG_D = 7'h42;
    localparam logic [6:0] SEG_E = 7'h30;
    localparam logic [6:0] SEG_F = 7'h38;

    function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/updown_counter_7seg_decode.sv
// One hex digit to 7-segment decoder; polarity selectable so the same table
// serves common-anode and common-cathode displays.
module seg7_hex_decode
    import updown_counter_7seg_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    logic [6:0] seg_raw;

    assign seg_raw = seg_lookup(nibble);
    assign seg     = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;

endmodule

// File: rtl/updown_counter_7seg.sv
// Prescaled up/down modulo counter with synchronous load, wrap pulse and a
// combinational hex display decode of the registered count.
module updown_counter_7seg
    import updown_counter_7seg_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int MODULUS        = 256,
    parameter int PRESCALE       = 5,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                   key0,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    output logic [WIDTH-1:0]       count,
    output logic                   tc,
    output logic [7*WIDTH/4-1:0]   hex
);

    localparam int DIV_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DIGITS = WIDTH / 4;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS = 2**WIDTH is representable for the load clamp.
    localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MODULUS);

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("updown_counter_7seg: WIDTH must be a positive multiple of 4");
        end
        if (longint'(MODULUS) > (longint'(1) << WIDTH) || MODULUS < 2) begin : g_bad_modulus
            $error("updown_counter_7seg: MODULUS must be in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("updown_counter_7seg: PRESCALE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q, count_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = ({1'b0, load_val} >= MOD_W) ? MAX_CNT : load_val;
            div_d   = '0;
        end else if (en) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (up == DIR_UP) begin
                    if (count_q == MAX_CNT) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = MAX_CNT;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge key0 or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            div_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

    // Digit k of the display follows nibble k of the registered count.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            seg7_hex_decode #(
                .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
            ) u_dec (
                .nibble(count_q[4*gi +: 4]),
                .seg   (hex[7*gi +: 7])
            );
        end
    endgenerate

endmodule

// File: tb/tb_updown_counter_7seg.sv
// Directed bench: three counter instances (mod 10 / mod 200 with prescale 5,
// and a 4-bit mod 16 prescale-1 active-high variant) sharing one stimulus.
module tb_updown_counter_7seg;

    logic        key0;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  load_val;

    logic [7:0]  count_a, count_b;
    logic [3:0]  count_c;
    logic        tc_a, tc_b, tc_c;
    logic [13:0] hex_a, hex_b;
    logic [6:0]  hex_c;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    updown_counter_7seg #(.WIDTH(8), .MODULUS(10), .PRESCALE(5), .SEG_ACTIVE_LOW(1'b1)) dut_a (
        .key0(key0), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .hex(hex_a)
    );

    updown_counter_7seg #(.WIDTH(8), .MODULUS(200), .PRESCALE(5), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .key0(key0), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count_b), .tc(tc_b), .hex(hex_b)
    );

    updown_counter_7seg #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .SEG_ACTIVE_LOW(1'b0)) dut_c (
        .key0(key0), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val[3:0]),
        .count(count_c), .tc(tc_c), .hex(hex_c)
    );

    initial key0 = 1'b0;
    always #5 key0 = ~key0;

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge key0);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (count_a !== 8'd0) begin failures++; $display("FAIL reset_count_a got=%0d exp=0", count_a); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL reset_tc_a got=%b exp=0", tc_a); end
        checks++; if (hex_a !== {7'h01, 7'h01}) begin failures++; $display("FAIL reset_hex_a got=%h exp=%h", hex_a, {7'h01, 7'h01}); end
        checks++; if (count_b !== 8'd0) begin failures++; $display("FAIL reset_count_b got=%0d exp=0", count_b); end
        checks++; if (hex_c !== 7'h7E) begin failures++; $display("FAIL reset_hex_c got=%h exp=7e", hex_c); end
        $display("reset: count_a=%0d tc_a=%b hex_a=%h hex_c=%h", count_a, tc_a, hex_a, hex_c);
        reset = 1'b1;
    endtask

    task automatic test_count_up();
        int ea, ec;
        en = 1'b1;
        up = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            ea = (k / 5) % 10;
            ec = k % 16;
            checks++; if (count_a !== 8'(ea)) begin failures++; $display("FAIL up_count_a k=%0d got=%0d exp=%0d", k, count_a, ea); end
            checks++; if (tc_a !== (k == 50)) begin failures++; $display("FAIL up_tc_a k=%0d got=%b exp=%b", k, tc_a, (k == 50)); end
            checks++; if (hex_a !== {seg_tbl[0], seg_tbl[ea]}) begin failures++; $display("FAIL up_hex_a k=%0d got=%h exp=%h", k, hex_a, {seg_tbl[0], seg_tbl[ea]}); end
            checks++; if (count_b !== 8'(k / 5)) begin failures++; $display("FAIL up_count_b k=%0d got=%0d exp=%0d", k, count_b, k / 5); end
            checks++; if (count_c !== 4'(ec)) begin failures++; $display("FAIL up_count_c k=%0d got=%0d exp=%0d", k, count_c, ec); end
            checks++; if (tc_c !== (ec == 0)) begin failures++; $display("FAIL up_tc_c k=%0d got=%b exp=%b", k, tc_c, (ec == 0)); end
            checks++; if (hex_c !== ~seg_tbl[ec]) begin failures++; $display("FAIL up_hex_c k=%0d got=%h exp=%h", k, hex_c, ~seg_tbl[ec]); end
            $display("up k=%0d count_a=%0d tc_a=%b count_b=%0d count_c=%0d tc_c=%b", k, count_a, tc_a, count_b, count_c, tc_c);
        end
    endtask

    task automatic test_count_down();
        int ea, eb, ec;
        up = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            ea = (k >= 5) ? 9 : 0;
            eb = (k >= 5) ? 9 : 10;
            ec = (2 - k + 16) % 16;
            checks++; if (count_a !== 8'(ea)) begin failures++; $display("FAIL down_count_a k=%0d got=%0d exp=%0d", k, count_a, ea); end
            checks++; if (tc_a !== (k == 5)) begin failures++; $display("FAIL down_tc_a k=%0d got=%b exp=%b", k, tc_a, (k == 5)); end
            checks++; if (hex_a !== {seg_tbl[0], seg_tbl[ea]}) begin failures++; $display("FAIL down_hex_a k=%0d got=%h exp=%h", k, hex_a, {seg_tbl[0], seg_tbl[ea]}); end
            checks++; if (count_b !== 8'(eb)) begin failures++; $display("FAIL down_count_b k=%0d got=%0d exp=%0d", k, count_b, eb); end
            checks++; if (count_c !== 4'(ec)) begin failures++; $display("FAIL down_count_c k=%0d got=%0d exp=%0d", k, count_c, ec); end
            checks++; if (tc_c !== (k == 3)) begin failures++; $display("FAIL down_tc_c k=%0d got=%b exp=%b", k, tc_c, (k == 3)); end
            $display("down k=%0d count_a=%0d tc_a=%b count_b=%0d count_c=%0d", k, count_a, tc_a, count_b, count_c);
        end
    endtask

    task automatic test_enable_hold();
        // Two more enabled edges bring the prescaler to 3 (count 9 unchanged).
        repeat (2) tick();
        checks++; if (count_a !== 8'd9) begin failures++; $display("FAIL pre_hold_count_a got=%0d exp=9", count_a); end
        checks++; if (count_c !== 4'd10) begin failures++; $display("FAIL pre_hold_count_c got=%0d exp=10", count_c); end
        en = 1'b0;
        up = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++; if (count_a !== 8'd9) begin failures++; $display("FAIL hold_count_a k=%0d got=%0d exp=9", k, count_a); end
            checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL hold_tc_a k=%0d got=%b exp=0", k, tc_a); end
            checks++; if (count_b !== 8'd9) begin failures++; $display("FAIL hold_count_b k=%0d got=%0d exp=9", k, count_b); end
            checks++; if (count_c !== 4'd10) begin failures++; $display("FAIL hold_count_c k=%0d got=%0d exp=10", k, count_c); end
            $display("hold k=%0d count_a=%0d count_b=%0d count_c=%0d", k, count_a, count_b, count_c);
        end
        en = 1'b1;
        tick();
        checks++; if (count_a !== 8'd9) begin failures++; $display("FAIL resume1_count_a got=%0d exp=9", count_a); end
        checks++; if (count_c !== 4'd11) begin failures++; $display("FAIL resume1_count_c got=%0d exp=11", count_c); end
        tick();
        checks++; if (count_a !== 8'd0) begin failures++; $display("FAIL resume2_count_a got=%0d exp=0", count_a); end
        checks++; if (tc_a !== 1'b1) begin failures++; $display("FAIL resume2_tc_a got=%b exp=1", tc_a); end
        checks++; if (count_b !== 8'd10) begin failures++; $display("FAIL resume2_count_b got=%0d exp=10", count_b); end
        tick();
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL resume3_tc_a got=%b exp=0", tc_a); end
        checks++; if (count_c !== 4'd13) begin failures++; $display("FAIL resume3_count_c got=%0d exp=13", count_c); end
        $display("resume count_a=%0d count_b=%0d count_c=%0d", count_a, count_b, count_c);
    endtask

    task automatic test_load_clamp();
        load     = 1'b1;
        load_val = 8'hC8;
        tick();
        load = 1'b0;
        checks++; if (count_a !== 8'd9) begin failures++; $display("FAIL clamp_count_a got=%0d exp=9", count_a); end
        checks++; if (count_b !== 8'd199) begin failures++; $display("FAIL clamp_count_b got=%0d exp=199", count_b); end
        checks++; if (hex_b !== {7'h31, 7'h0F}) begin failures++; $display("FAIL clamp_hex_b got=%h exp=%h", hex_b, {7'h31, 7'h0F}); end
        checks++; if (count_c !== 4'd8) begin failures++; $display("FAIL clamp_count_c got=%0d exp=8", count_c); end
        checks++; if (hex_c !== 7'h7F) begin failures++; $display("FAIL clamp_hex_c got=%h exp=7f", hex_c); end
        checks++; if (tc_a !== 1'b0 || tc_b !== 1'b0) begin failures++; $display("FAIL clamp_tc got=%b%b exp=00", tc_a, tc_b); end
        $display("load C8: count_a=%0d count_b=%0d hex_b=%h count_c=%0d", count_a, count_b, hex_b, count_c);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (count_a !== ((k == 5) ? 8'd0 : 8'd9)) begin failures++; $display("FAIL clamp_run_count_a k=%0d got=%0d", k, count_a); end
            checks++; if (count_b !== ((k == 5) ? 8'd0 : 8'd199)) begin failures++; $display("FAIL clamp_run_count_b k=%0d got=%0d", k, count_b); end
            checks++; if (tc_b !== (k == 5)) begin failures++; $display("FAIL clamp_run_tc_b k=%0d got=%b exp=%b", k, tc_b, (k == 5)); end
            checks++; if (count_c !== 4'(8 + k)) begin failures++; $display("FAIL clamp_run_count_c k=%0d got=%0d exp=%0d", k, count_c, 8 + k); end
            $display("after load k=%0d count_a=%0d count_b=%0d tc_b=%b count_c=%0d", k, count_a, count_b, tc_b, count_c);
        end
    endtask

    task automatic test_load_priority();
        repeat (4) tick();
        load     = 1'b1;
        load_val = 8'h03;
        tick();
        load = 1'b0;
        checks++; if (count_a !== 8'd3) begin failures++; $display("FAIL prio_count_a got=%0d exp=3", count_a); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL prio_tc_a got=%b exp=0", tc_a); end
        checks++; if (count_b !== 8'd3) begin failures++; $display("FAIL prio_count_b got=%0d exp=3", count_b); end
        checks++; if (count_c !== 4'd3) begin failures++; $display("FAIL prio_count_c got=%0d exp=3", count_c); end
        $display("load+en: count_a=%0d count_b=%0d count_c=%0d", count_a, count_b, count_c);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (count_a !== ((k == 5) ? 8'd4 : 8'd3)) begin failures++; $display("FAIL prio_run_count_a k=%0d got=%0d", k, count_a); end
        end
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'hFF;
        tick();
        load = 1'b0;
        checks++; if (count_a !== 8'd9) begin failures++; $display("FAIL load_noen_count_a got=%0d exp=9", count_a); end
        checks++; if (count_b !== 8'd199) begin failures++; $display("FAIL load_noen_count_b got=%0d exp=199", count_b); end
        checks++; if (count_c !== 4'd15) begin failures++; $display("FAIL load_noen_count_c got=%0d exp=15", count_c); end
        $display("load FF en=0: count_a=%0d count_b=%0d count_c=%0d", count_a, count_b, count_c);
    endtask

    task automatic test_reset_midway();
        en       = 1'b1;
        load     = 1'b1;
        load_val = 8'h05;
        tick();
        load = 1'b0;
        repeat (2) tick();
        checks++; if (count_a !== 8'd5) begin failures++; $display("FAIL mid_pre_count_a got=%0d exp=5", count_a); end
        #3;
        reset = 1'b0;
        #1;
        checks++; if (count_a !== 8'd0) begin failures++; $display("FAIL mid_count_a got=%0d exp=0", count_a); end
        checks++; if (tc_a !== 1'b0) begin failures++; $display("FAIL mid_tc_a got=%b exp=0", tc_a); end
        checks++; if (hex_a !== {7'h01, 7'h01}) begin failures++; $display("FAIL mid_hex_a got=%h exp=%h", hex_a, {7'h01, 7'h01}); end
        checks++; if (count_b !== 8'd0) begin failures++; $display("FAIL mid_count_b got=%0d exp=0", count_b); end
        checks++; if (hex_c !== 7'h7E) begin failures++; $display("FAIL mid_hex_c got=%h exp=7e", hex_c); end
        $display("async reset: count_a=%0d hex_a=%h count_b=%0d hex_c=%h", count_a, hex_a, count_b, hex_c);
        #1;
        reset = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (count_a !== ((k == 5) ? 8'd1 : 8'd0)) begin failures++; $display("FAIL post_reset_count_a k=%0d got=%0d", k, count_a); end
            checks++; if (count_c !== 4'(k)) begin failures++; $display("FAIL post_reset_count_c k=%0d got=%0d exp=%0d", k, count_c, k); end
            $display("post reset k=%0d count_a=%0d count_c=%0d", k, count_a, count_c);
        end
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = 8'h00;
        test_reset();
        test_count_up();
        test_count_down();
        test_enable_hold();
        test_load_clamp();
        test_load_priority();
        test_reset_midway();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
